freq_counter_bcd: RTL and testbench

FREQ_COUNTER_BCD -- requirements
Module: freq_counter_bcd

---
 rtl/freq_counter_bcd.sv | 126 ++++++++++++
 tb/tb_freq_counter_bcd.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_bcd.sv
// Reciprocal-free frequency counter: counts synchronized signal edges over a
// programmable window, then converts the count to BCD with shift-and-add-3.

module freq_counter_bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  always_comb adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

module freq_counter_bcd #(
  parameter int DIGITS        = 4,
  parameter int BITS          = 16,
  parameter int UPDATE_PERIOD = 1200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  signal,
  input  logic [BITS-1:0]       period,
  input  logic                  period_load,
  input  logic [1:0]            edge_mode,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  overflow
);
  localparam int CW  = $clog2(10**DIGITS);
  localparam int BCW = $clog2(CW + 1);
  localparam logic [CW-1:0]   MAXV       = CW'(10**DIGITS - 1);
  localparam logic [BITS-1:0] RST_PERIOD = BITS'(UPDATE_PERIOD);

  typedef enum logic [1:0] {COUNT = 2'd0, CONVERT = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic                s0, s1, s2;
  logic                rise, fall, edge_hit;
  logic [BITS-1:0]     pending_period, active_period, win_cnt;
  logic [CW-1:0]       edge_cnt, cnt_next, conv_bin;
  logic                ovf_flag, ovf_next;
  logic [4*DIGITS-1:0] conv_bcd, adj, step;
  logic [BCW-1:0]      bit_cnt;

  // s0/s1 synchronize; s2 is the delay flop the edge detector compares against
  always_ff @(posedge clk) {s2, s1, s0} <= {s1, s0, signal};

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  always_comb begin
    case (edge_mode)
      2'd1:    edge_hit = fall;
      2'd2:    edge_hit = rise | fall;
      default: edge_hit = rise;
    endcase
  end

  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf_flag;
    if (edge_hit) begin
      if (edge_cnt == MAXV) ovf_next = 1'b1;
      else                  cnt_next = edge_cnt + 1'b1;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    freq_counter_bcd_add3 u_add3 (.digit(conv_bcd[4*d +: 4]), .adjusted(adj[4*d +: 4]));
  end
  assign step = {adj[4*DIGITS-2:0], conv_bin[CW-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COUNT;
      pending_period <= RST_PERIOD;
      active_period  <= RST_PERIOD;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      ovf_flag       <= 1'b0;
      conv_bin       <= '0;
      conv_bcd       <= '0;
      bit_cnt        <= '0;
      bcd            <= '0;
      valid          <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (period_load) pending_period <= period;
      case (state)
        COUNT: begin
          edge_cnt <= cnt_next;
          ovf_flag <= ovf_next;
          if (win_cnt == active_period) begin
            conv_bin <= cnt_next;
            conv_bcd <= '0;
            bit_cnt  <= '0;
            state    <= CONVERT;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        CONVERT: begin
          conv_bcd <= step;
          conv_bin <= {conv_bin[CW-2:0], 1'b0};
          bit_cnt  <= bit_cnt + 1'b1;
          // Results are published on the edge into DONE so valid is seen CW+1 cycles after the window
          if (bit_cnt == BCW'(CW - 1)) begin
            bcd      <= step;
            overflow <= ovf_flag;
            valid    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          valid         <= 1'b0;
          edge_cnt      <= '0;
          ovf_flag      <= 1'b0;
          win_cnt       <= '0;
          active_period <= pending_period;
          state         <= COUNT;
        end
        default: begin
          valid <= 1'b0;
          state <= COUNT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_freq_counter_bcd.sv
// Directed bench for freq_counter_bcd (DIGITS=4, BITS=16): expected results are
// queued as stimulus is set up and checked by a monitor on each valid pulse.

module tb_freq_counter_bcd;
  localparam int UPD = 1200;
  localparam int CW  = 14;

  logic        clk = 1'b0;
  logic        reset, signal, period_load;
  logic [15:0] period;
  logic [1:0]  edge_mode;
  logic [15:0] bcd;
  logic        valid, overflow;

  freq_counter_bcd #(.DIGITS(4), .BITS(16), .UPDATE_PERIOD(UPD)) dut (
    .clk(clk), .reset(reset), .signal(signal), .period(period),
    .period_load(period_load), .edge_mode(edge_mode),
    .bcd(bcd), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          check;
    logic [15:0] bcd;
    logic [15:0] alt;
    logic        ovf;
    int          gap;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, last_vcyc = 0, c0;
  bit          prev_valid = 1'b0;
  bit          hold_known = 1'b0;
  logic [15:0] hold_exp = '0;
  logic        hold_ovf = 1'b0;
  bit          wave_on = 1'b0;
  int          half = 2, ph = 0;

  always @(posedge clk) cyc++;

  // square wave: signal toggles every `half` clocks
  initial signal = 1'b0;
  always @(negedge clk) begin
    if (wave_on) begin
      ph++;
      if (ph >= half) begin
        ph = 0;
        signal = ~signal;
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++; $error("FAIL unexpected_valid: got valid=1 at cycle %0d, want no valid", cyc);
      end
      n_cmp++;
      assert (prev_valid === 1'b0) else begin
        n_err++; $error("FAIL valid_width: got valid high 2 cycles, want 1-cycle pulse");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        if (mon_e.check) begin
          n_cmp++;
          assert (bcd === mon_e.bcd || bcd === mon_e.alt) else begin
            n_err++; $error("FAIL %s bcd: got %h, want %h or %h", mon_e.tag, bcd, mon_e.bcd, mon_e.alt);
          end
          n_cmp++;
          assert (overflow === mon_e.ovf) else begin
            n_err++; $error("FAIL %s overflow: got %b, want %b", mon_e.tag, overflow, mon_e.ovf);
          end
          if (mon_e.gap >= 0) begin
            n_cmp++;
            assert (cyc - last_vcyc === mon_e.gap) else begin
              n_err++; $error("FAIL %s spacing: got %0d, want %0d", mon_e.tag, cyc - last_vcyc, mon_e.gap);
            end
          end
          if (mon_e.at >= 0) begin
            n_cmp++;
            assert (cyc === mon_e.at) else begin
              n_err++; $error("FAIL %s latency: got cycle %0d, want %0d", mon_e.tag, cyc, mon_e.at);
            end
          end
        end
        hold_known = mon_e.check && (mon_e.bcd == mon_e.alt);
        hold_exp   = mon_e.bcd;
        hold_ovf   = mon_e.ovf;
      end else begin
        hold_known = 1'b0;
      end
      last_vcyc = cyc;
    end else if (hold_known) begin
      n_cmp++;
      assert (bcd === hold_exp && overflow === hold_ovf) else begin
        n_err++; $error("FAIL hold: got bcd=%h ovf=%b, want bcd=%h ovf=%b", bcd, overflow, hold_exp, hold_ovf);
      end
    end
    prev_valid = valid;
  end

  task automatic push(input string tag, input bit check, input logic [15:0] b,
                      input logic [15:0] a, input logic o, input int gap, input int at);
    exp_t e;
    e.tag = tag; e.check = check; e.bcd = b; e.alt = a; e.ovf = o; e.gap = gap; e.at = at;
    sb.push_back(e);
  endtask

  task automatic stale(input string tag);
    push(tag, 1'b0, 16'h0, 16'h0, 1'b0, -1, -1);
  endtask

  task automatic drain(input string tag, input int lim);
    int t = 0;
    while (sb.size() != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++; $error("FAIL %s timeout: got %0d results outstanding, want 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic load(input logic [15:0] p);
    period = p;
    period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    n_cmp++;
    assert (bcd === 16'h0) else begin
      n_err++; $error("FAIL %s bcd: got %h, want 0000", tag, bcd);
    end
    n_cmp++;
    assert (valid === 1'b0) else begin
      n_err++; $error("FAIL %s valid: got %b, want 0", tag, valid);
    end
    n_cmp++;
    assert (overflow === 1'b0) else begin
      n_err++; $error("FAIL %s overflow: got %b, want 0", tag, overflow);
    end
  endtask

  initial begin
    reset = 1'b1; period = '0; period_load = 1'b0; edge_mode = 2'd0;
    half = 2; wave_on = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    reset = 1'b0;
    hold_exp = '0; hold_ovf = 1'b0; hold_known = 1'b1;

    // Pulse reset while the first window is being converted: that result must never appear
    c0 = cyc;
    while (cyc < c0 + UPD + 5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    // counting the cycle reset drops in as cycle 1, valid lands in cycle UPD+1+CW+1
    push("reset_mid_convert", 1'b1, 16'h0300, 16'h0301, 1'b0, -1, c0 + UPD + CW + 1);
    drain("reset_mid_convert", UPD + 200);

    repeat (2) @(negedge clk);
    load(16'd99);
    stale("rise_p99");
    repeat (3) push("rise_p99", 1'b1, 16'h0025, 16'h0025, 1'b0, 99 + 1 + CW + 1, -1);
    drain("rise_p99", UPD + 600);

    repeat (2) @(negedge clk);
    edge_mode = 2'd2;
    stale("both_edges");
    repeat (2) push("both_edges", 1'b1, 16'h0050, 16'h0050, 1'b0, 115, -1);
    drain("both_edges", 500);

    repeat (2) @(negedge clk);
    edge_mode = 2'd1;
    stale("fall_edges");
    repeat (2) push("fall_edges", 1'b1, 16'h0025, 16'h0025, 1'b0, 115, -1);
    drain("fall_edges", 500);

    repeat (2) @(negedge clk);
    wave_on = 1'b0;
    edge_mode = 2'd2;
    stale("constant");
    repeat (2) push("constant", 1'b1, 16'h0000, 16'h0000, 1'b0, 115, -1);
    drain("constant", 500);

    repeat (2) @(negedge clk);
    wave_on = 1'b1;
    edge_mode = 2'd0;
    stale("load_mid_window");
    drain("load_mid_window", 300);
    repeat (30) @(negedge clk);
    load(16'd49);
    push("load_mid_window_old", 1'b1, 16'h0025, 16'h0025, 1'b0, 115, -1);
    repeat (2) push("load_mid_window_new", 1'b1, 16'h0012, 16'h0013, 1'b0, 49 + 1 + CW + 1, -1);
    drain("load_mid_window", 500);

    repeat (2) @(negedge clk);
    load(16'd0);
    stale("period_zero");
    repeat (2) push("period_zero", 1'b1, 16'h0000, 16'h0001, 1'b0, 0 + 1 + CW + 1, -1);
    drain("period_zero", 300);

    repeat (2) @(negedge clk);
    load(16'hFFFF);
    half = 1;
    stale("saturate");
    drain("saturate", 200);
    repeat (5) @(negedge clk);
    load(16'd99);
    push("saturate", 1'b1, 16'h9999, 16'h9999, 1'b1, 65535 + 1 + CW + 1, -1);
    drain("saturate", 66000);

    // Reset wins over a same-cycle period_load: the next window is UPDATE_PERIOD long
    repeat (2) @(negedge clk);
    hold_known = 1'b0;
    half = 2;
    reset = 1'b1;
    period = 16'd5;
    period_load = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset_after_ovf");
    reset = 1'b0;
    period_load = 1'b0;
    c0 = cyc;
    hold_exp = '0; hold_ovf = 1'b0; hold_known = 1'b1;
    push("reset_vs_load", 1'b1, 16'h0300, 16'h0301, 1'b0, -1, c0 + UPD + CW + 1);
    drain("reset_vs_load", UPD + 200);

    repeat (2) @(negedge clk);
    load(16'd99);
    stale("recover");
    push("recover", 1'b1, 16'h0025, 16'h0025, 1'b0, 115, -1);
    drain("recover", UPD + 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
